// File: rtl/jam_cost_table.sv
// -----------------------------------------------------------------------------
// jam_cost_table
//   Cost-table responder for the job-assignment (JAM) engine. Owns an N x N
//   worker/job cost table, fills it from a valid/ready byte stream in row-major
//   order, then answers W/J lookups combinationally. While the table loads, the
//   block accumulates the sum of per-row minimum costs (LowerBound) for pruning.
//   The JAM engine is held in reset (JamRst=1) until the table is complete.
//
// Ports
//   CLK         in   1      clock, rising edge
//   RST_N       in   1      synchronous active-low reset (also zeroes the table)
//   LdValid     in   1      load stream valid
//   LdData      in   CW     load stream cost entry (W major, J minor)
//   LdReady     out  1      table accepts an entry (LOAD state)
//   Clear       in   1      restart loading; table contents kept until overwritten
//   W           in   IW     worker index of lookup
//   J           in   IW     job index of lookup
//   Cost        out  CW     table[W][J] in SERVE, 0 in LOAD
//   TableReady  out  1      table complete, lookups valid
//   JamRst      out  1      registered active-high reset for the JAM engine
//   LowerBound  out  10     registered sum of row minima (0 while loading)
// -----------------------------------------------------------------------------
module jam_cost_table #(
  parameter int N  = 8,
  parameter int CW = 7
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  LdValid,
  input  logic [CW-1:0]         LdData,
  output logic                  LdReady,
  input  logic                  Clear,
  input  logic [$clog2(N)-1:0]  W,
  input  logic [$clog2(N)-1:0]  J,
  output logic [CW-1:0]         Cost,
  output logic                  TableReady,
  output logic                  JamRst,
  output logic [9:0]            LowerBound
);

  localparam int IW = $clog2(N);
  localparam int PW = 2 * IW;

  localparam logic [0:0] S_LOAD  = 1'b0;
  localparam logic [0:0] S_SERVE = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] row_min_q, row_min_d;
  logic [9:0]    acc_q, acc_d;
  logic [9:0]    lb_q, lb_d;
  logic          jam_rst_q, jam_rst_d;
  logic [CW-1:0] table_q [N*N];

  logic          xfer;
  logic          wr_en;
  logic [CW-1:0] merged_min;

  assign xfer       = LdValid && (state_q == S_LOAD);
  assign merged_min = (LdData < row_min_q) ? LdData : row_min_q;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    row_min_d = row_min_q;
    acc_d     = acc_q;
    wr_en     = 1'b0;

    if (Clear) begin
      // Clear wins over a simultaneous transfer: that entry is dropped.
      state_d   = S_LOAD;
      ptr_d     = '0;
      row_min_d = '1;
      acc_d     = '0;
    end else if (xfer) begin
      wr_en = 1'b1;
      ptr_d = ptr_q + 1'b1;
      if (ptr_q[IW-1:0] == '1) begin
        // Last entry of a row: fold the row minimum into the bound and rearm.
        acc_d     = acc_q + 10'(merged_min);
        row_min_d = '1;
      end else begin
        row_min_d = merged_min;
      end
      if (ptr_q == '1) state_d = S_SERVE;
    end

    // Bound and engine reset follow the next state so both line up with TableReady.
    lb_d      = (state_d == S_SERVE) ? acc_d : '0;
    jam_rst_d = (state_d == S_LOAD);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= S_LOAD;
      ptr_q     <= '0;
      row_min_q <= '1;
      acc_q     <= '0;
      lb_q      <= '0;
      jam_rst_q <= 1'b1;
      // NOTE: the table is deliberately cleared on reset (Clear keeps it), so it
      // is built from resettable flops rather than a RAM macro.
      for (int i = 0; i < N*N; i++) table_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      row_min_q <= row_min_d;
      acc_q     <= acc_d;
      lb_q      <= lb_d;
      jam_rst_q <= jam_rst_d;
      if (wr_en) table_q[ptr_q] <= LdData;
    end
  end

  assign LdReady    = (state_q == S_LOAD);
  assign TableReady = (state_q == S_SERVE);
  assign JamRst     = jam_rst_q;
  assign LowerBound = lb_q;
  assign Cost       = (state_q == S_SERVE) ? table_q[{W, J}] : '0;

endmodule

// File: tb/tb_jam_cost_table.sv
// -----------------------------------------------------------------------------
// tb_jam_cost_table
//   Self-checking bench for jam_cost_table. A behavioural model holds the table
//   as a plain array plus an entry count; when the 64th entry lands it computes
//   the bound directly as the sum of row minima. Every negedge the DUT outputs
//   are compared with the model; literal expectations pin the model.
// -----------------------------------------------------------------------------
module tb_jam_cost_table;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       LdValid;
  logic [6:0] LdData;
  logic       LdReady;
  logic       Clear;
  logic [2:0] W;
  logic [2:0] J;
  logic [6:0] Cost;
  logic       TableReady;
  logic       JamRst;
  logic [9:0] LowerBound;

  jam_cost_table #(.N(8), .CW(7)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .LdValid    (LdValid),
    .LdData     (LdData),
    .LdReady    (LdReady),
    .Clear      (Clear),
    .W          (W),
    .J          (J),
    .Cost       (Cost),
    .TableReady (TableReady),
    .JamRst     (JamRst),
    .LowerBound (LowerBound)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  bit rand_wj = 1'b1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_tab [64];
  bit m_serve = 1'b0;
  bit m_valid = 1'b0;
  int m_cnt   = 0;
  int m_lb    = 0;

  function automatic int row_min_sum();
    int s = 0;
    for (int w = 0; w < 8; w++) begin
      int mn = 127;
      for (int j = 0; j < 8; j++) if (m_tab[w*8+j] < mn) mn = m_tab[w*8+j];
      s += mn;
    end
    return s;
  endfunction

  always @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < 64; i++) m_tab[i] = 0;
      m_serve = 1'b0;
      m_cnt   = 0;
      m_lb    = 0;
      m_valid = 1'b1;
    end else if (Clear) begin
      m_serve = 1'b0;
      m_cnt   = 0;
      m_lb    = 0;
    end else if (!m_serve && LdValid) begin
      m_tab[m_cnt] = int'(LdData);
      m_cnt++;
      if (m_cnt == 64) begin
        m_serve = 1'b1;
        m_lb    = row_min_sum();
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge CLK) begin
    if (m_valid) begin
      check("LdReady",    int'(LdReady),    int'(!m_serve));
      check("TableReady", int'(TableReady), int'(m_serve));
      check("JamRst",     int'(JamRst),     int'(!m_serve));
      check("LowerBound", int'(LowerBound), m_serve ? m_lb : 0);
      check("Cost",       int'(Cost),       m_serve ? m_tab[int'(W)*8 + int'(J)] : 0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge CLK);
    #1;
    if (rand_wj) begin
      W = 3'($urandom);
      J = 3'($urandom);
    end
  endtask

  function automatic logic [6:0] pat(input int kind, input int idx);
    int w = idx / 8;
    int j = idx % 8;
    case (kind)
      0:       return 7'(w + j);
      1:       return 7'd127;
      2:       return (idx == 4*8+6) ? 7'd3 : 7'd127;
      3:       return 7'(7 - j);
      default: return 7'($urandom_range(0, 127));
    endcase
  endfunction

  // mode 0: back-to-back, 1: valid every other cycle plus a 10-cycle gap at
  // entry 31, 2: random gaps. abort_at >= 0 applies Clear (or reset) together
  // with that entry and stops the load.
  task automatic load(input int kind, input int mode, input int abort_at, input bit abort_rst);
    for (int i = 0; i < 64; i++) begin
      if (mode == 1) begin
        cyc();
        if (i == 31) repeat (10) cyc();
      end else if (mode == 2) begin
        repeat ($urandom_range(0, 2)) cyc();
      end
      LdValid = 1'b1;
      LdData  = pat(kind, i);
      if (i == abort_at) begin
        if (abort_rst) RST_N = 1'b0;
        else           Clear = 1'b1;
        cyc();
        RST_N   = 1'b1;
        Clear   = 1'b0;
        LdValid = 1'b0;
        return;
      end
      cyc();
      LdValid = 1'b0;
    end
  endtask

  task automatic clear_pulse();
    Clear = 1'b1;
    cyc();
    Clear = 1'b0;
  endtask

  task automatic probe(input int w, input int j, input string name, input int exp);
    rand_wj = 1'b0;
    W = 3'(w);
    J = 3'(j);
    #1;
    check(name, int'(Cost), exp);
    rand_wj = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    RST_N   = 1'b0;
    LdValid = 1'b0;
    LdData  = '0;
    Clear   = 1'b0;
    W       = '0;
    J       = '0;
    repeat (2) cyc();

    // 1: reset values for several W/J
    rand_wj = 1'b0;
    for (int k = 0; k < 4; k++) begin
      W = 3'($urandom);
      J = 3'($urandom);
      #1;
      check("rst_cost",       int'(Cost),       0);
      check("rst_ldready",    int'(LdReady),    1);
      check("rst_tableready", int'(TableReady), 0);
      check("rst_jamrst",     int'(JamRst),     1);
      check("rst_lowerbound", int'(LowerBound), 0);
    end
    rand_wj = 1'b1;
    RST_N = 1'b1;
    cyc();

    // 2: back-to-back w+j load
    load(0, 0, -1, 1'b0);
    check("t2_tableready", int'(TableReady), 1);
    check("t2_jamrst",     int'(JamRst),     0);
    check("t2_lowerbound", int'(LowerBound), 28);
    probe(3, 5, "t2_cost_3_5", 8);

    // 3: same load with toggled valid and a long gap; valid after completion ignored
    clear_pulse();
    load(0, 1, -1, 1'b0);
    check("t3_lowerbound", int'(LowerBound), 28);
    LdValid = 1'b1;
    LdData  = 7'd0;
    repeat (5) cyc();
    LdValid = 1'b0;
    probe(3, 5, "t3_cost_3_5", 8);

    // 4: all 127, then one entry of row 4 lowered to 3
    clear_pulse();
    load(1, 2, -1, 1'b0);
    check("t4_lb_all127", int'(LowerBound), 1016);
    clear_pulse();
    load(2, 0, -1, 1'b0);
    check("t4_lb_row4", int'(LowerBound), 892);
    probe(4, 6, "t4_cost_4_6", 3);

    // 5: Clear at entry 20, then reload 7-j
    clear_pulse();
    load(4, 0, 20, 1'b0);
    load(3, 2, -1, 1'b0);
    check("t5_lowerbound", int'(LowerBound), 0);
    probe(0, 0, "t5_cost_0_0", 7);

    // 6: Clear with a simultaneous valid in SERVE; 99 must be dropped
    Clear   = 1'b1;
    LdValid = 1'b1;
    LdData  = 7'd99;
    cyc();
    Clear   = 1'b0;
    LdValid = 1'b0;
    check("t6_tableready", int'(TableReady), 0);
    check("t6_jamrst",     int'(JamRst),     1);
    check("t6_lowerbound", int'(LowerBound), 0);
    load(3, 0, -1, 1'b0);
    probe(0, 0, "t6_cost_0_0", 7);

    // 7: reset at entry 40, then a fresh load starts at table[0][0]
    clear_pulse();
    load(4, 0, 40, 1'b1);
    check("t7_ldready",    int'(LdReady),    1);
    check("t7_tableready", int'(TableReady), 0);
    check("t7_jamrst",     int'(JamRst),     1);
    check("t7_lowerbound", int'(LowerBound), 0);
    check("t7_cost",       int'(Cost),       0);
    load(3, 0, -1, 1'b0);
    probe(0, 0, "t7_cost_0_0", 7);

    // random tables with random gaps
    repeat (4) begin
      clear_pulse();
      load(4, 2, -1, 1'b0);
      repeat (12) cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
